shared_mem_xbar: RTL and testbench

Parametrised shared-memory crossbar for the GPU. It connects `NUM_CORES` core load/store ports to `NUM_BANKS` address-interleaved single-port banks. Each bank has a round-robin arbiter, and bank conflicts are counted. It replaces the fixed 16×16 bank-arbiter array: the core-side `read`/`write`/`addr_in`/`data_in`/`data_out`/`finish` buses keep the same meaning, widened by parameter.

---
 rtl/gpu_mem_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/shared_mem_xbar.sv | 133 +++++++++++++
 tb/tb_shared_mem_xbar.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU shared-memory crossbar.
// Holds the default geometry, the conflict counter width and a clog2 helper
// that works in constant (parameter) contexts.
package gpu_mem_pkg;

  localparam int unsigned DefNumCores = 16;
  localparam int unsigned DefNumBanks = 16;
  localparam int unsigned DefAddrW    = 12;
  localparam int unsigned DefDataW    = 8;
  localparam int unsigned CntW        = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

  // Bank-select and row widths for the default geometry.
  localparam int unsigned DefBw   = clog2(DefNumBanks);
  localparam int unsigned DefRowW = DefAddrW - DefBw;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one per memory bank.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer returns to 0)
//   req        : per-core request vector
//   gnt        : one-hot grant (all zero when no request)
//   multi      : two or more requests present this cycle (bank conflict)
module rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         multi
);

  localparam int unsigned PW = clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Search upward from the pointer with wrap; the first requester wins and
  // the pointer moves just past it so it becomes lowest priority next time.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = PW'((32'(idx) + 1) % N);
        found    = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if >= 2 bits were set.
  assign multi = |(req & (req - N'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_mem_xbar.sv
// Shared-memory crossbar: NUM_CORES load/store ports onto NUM_BANKS
// address-interleaved single-port banks, one round-robin arbiter per bank.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   read, write  : per-core level requests (write wins if both set)
//   addr_in      : per-core word address, core k at [k*ADDR_W +: ADDR_W]
//   data_in      : per-core store data, core k at [k*DATA_W +: DATA_W]
//   data_out     : per-core registered load data, held until next load
//   finish       : per-core one-cycle completion pulse
//   conflict_cnt : saturating count of cycles with any bank conflict
module shared_mem_xbar
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_CORES = DefNumCores,
  parameter int unsigned NUM_BANKS = DefNumBanks,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        read,
  input  logic [NUM_CORES-1:0]        write,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
  input  logic [NUM_CORES*DATA_W-1:0] data_in,
  output logic [NUM_CORES*DATA_W-1:0] data_out,
  output logic [NUM_CORES-1:0]        finish,
  output logic [CntW-1:0]             conflict_cnt
);

  localparam int unsigned BW    = clog2(NUM_BANKS);
  localparam int unsigned RowW  = ADDR_W - BW;
  localparam int unsigned Depth = 1 << RowW;

  logic [NUM_CORES-1:0]        finish_q, elig, granted;
  logic [NUM_CORES*DATA_W-1:0] data_out_q, data_out_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]               core_bank [NUM_CORES];
  logic [RowW-1:0]             core_row  [NUM_CORES];
  logic [NUM_CORES-1:0]        bank_gnt  [NUM_BANKS];
  logic [DATA_W-1:0]           bank_rdata[NUM_BANKS];
  logic [NUM_BANKS-1:0]        bank_multi;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    assign core_bank[k] = addr_in[k*ADDR_W +: BW];
    assign core_row[k]  = addr_in[k*ADDR_W+BW +: RowW];
  end

  // A core still showing finish is masked so a held request is not served twice.
  assign elig = (read | write) & ~finish_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_CORES-1:0] req;
    logic [RowW-1:0]      row;
    logic [DATA_W-1:0]    wdata;
    logic                 we;
    logic [DATA_W-1:0]    mem [Depth];

    always_comb begin
      req = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        req[k] = elig[k] && (core_bank[k] == BW'(b));
      end
    end

    rr_arbiter #(
      .N (NUM_CORES)
    ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gnt   (bank_gnt[b]),
      .multi (bank_multi[b])
    );

    // Grant is one-hot, so OR-ing masked fields selects the winner's fields.
    always_comb begin
      row   = '0;
      wdata = '0;
      we    = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
        if (bank_gnt[b][k]) begin
          row   = row | core_row[k];
          wdata = wdata | data_in[k*DATA_W +: DATA_W];
          we    = we | write[k];
        end
      end
    end

    // Contents are not reset; the reset check only suppresses the commit.
    always_ff @(posedge clk) begin
      if (!reset && we) mem[row] <= wdata;
    end

    assign bank_rdata[b] = mem[row];
  end

  always_comb begin
    logic [DATA_W-1:0] rd;
    granted    = '0;
    data_out_d = data_out_q;
    rd         = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      rd = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        granted[k] = granted[k] | bank_gnt[b][k];
        rd         = rd | ({DATA_W{bank_gnt[b][k]}} & bank_rdata[b]);
      end
      if (granted[k] && !write[k]) data_out_d[k*DATA_W +: DATA_W] = rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((|bank_multi) && (cnt_q != {CntW{1'b1}})) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q   <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
    end else begin
      finish_q   <= granted;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign finish       = finish_q;
  assign data_out     = data_out_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_shared_mem_xbar.sv
// Bench for shared_mem_xbar: directed scenarios plus random traffic, checked
// against a cycle-level reference model built from the crossbar's rules.
module tb_shared_mem_xbar;

  localparam int NC = 16;
  localparam int NB = 16;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BWT = 4;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    read, write;
  logic [NC*AW-1:0] addr_in;
  logic [NC*DW-1:0] data_in;
  logic [NC*DW-1:0] data_out;
  logic [NC-1:0]    finish;
  logic [15:0]      conflict_cnt;

  logic [3:0]  s_read, s_write, s_finish;
  logic [47:0] s_addr;
  logic [63:0] s_din, s_dout;
  logic [15:0] s_cnt;

  int checks;
  int errors;

  // Reference model state.
  logic [NC-1:0] m_fin;
  logic [DW-1:0] m_dout [NC];
  bit            m_known[NC];
  logic [DW-1:0] m_mem  [int];
  int            m_ptr  [NB];
  int            m_cnt;

  shared_mem_xbar dut (
    .clk          (clk),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .finish       (finish),
    .conflict_cnt (conflict_cnt)
  );

  shared_mem_xbar #(
    .NUM_CORES (4),
    .NUM_BANKS (2),
    .ADDR_W    (12),
    .DATA_W    (16)
  ) dut_s (
    .clk          (clk),
    .reset        (reset),
    .read         (s_read),
    .write        (s_write),
    .addr_in      (s_addr),
    .data_in      (s_din),
    .data_out     (s_dout),
    .finish       (s_finish),
    .conflict_cnt (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bank_of(input int k);
    return int'(addr_in[k*AW +: BWT]);
  endfunction

  function automatic int addr_of(input int k);
    return int'(addr_in[k*AW +: AW]);
  endfunction

  task automatic model_reset();
    m_fin = '0;
    m_cnt = 0;
    for (int k = 0; k < NC; k++) begin
      m_dout[k]  = '0;
      m_known[k] = 1'b1;
    end
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
  endtask

  task automatic model_step();
    logic [NC-1:0] elig, gnt;
    bit conflict;
    int n, c, a;
    elig     = (read | write) & ~m_fin;
    gnt      = '0;
    conflict = 1'b0;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      for (int k = 0; k < NC; k++) if (elig[k] && bank_of(k) == b) n++;
      if (n >= 2) conflict = 1'b1;
      for (int i = 0; i < NC; i++) begin
        c = (m_ptr[b] + i) % NC;
        if (elig[c] && bank_of(c) == b) begin
          gnt[c]   = 1'b1;
          m_ptr[b] = (c + 1) % NC;
          break;
        end
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (gnt[k]) begin
        a = addr_of(k);
        if (write[k]) begin
          m_mem[a] = data_in[k*DW +: DW];
        end else if (m_mem.exists(a)) begin
          m_dout[k]  = m_mem[a];
          m_known[k] = 1'b1;
        end else begin
          m_known[k] = 1'b0;
        end
      end
    end
    m_fin = gnt;
    if (conflict && m_cnt < 65535) m_cnt++;
  endtask

  // Advance one clock: model consumes the inputs seen at this edge.
  task automatic tick();
    if (reset) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit rd, input bit wr, input int a, input int d);
    read[k]                = rd;
    write[k]               = wr;
    addr_in[k*AW +: AW]    = AW'(a);
    data_in[k*DW +: DW]    = DW'(d);
  endtask

  // Drop each request once it finishes; wait until all are gone.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < NC; k++) begin
        if (m_fin[k]) begin
          read[k]  = 1'b0;
          write[k] = 1'b0;
        end
      end
      if ((read | write) == '0) break;
      tick();
    end
    checks++;
    if ((read | write) != '0) begin
      errors++;
      $display("FAIL drain_timeout pending %h required 0", read | write);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    read  = NC'($urandom);
    write = NC'($urandom);
    for (int k = 0; k < NC; k++) set_req(k, read[k], write[k], $urandom, $urandom);
    repeat (3) tick();
    checks++;
    if (finish !== '0) begin
      errors++; $display("FAIL reset_finish got %h required 0", finish);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_data_out got %h required 0", data_out);
    end
    checks++;
    if (conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got %h required 0", conflict_cnt);
    end
    read  = '0;
    write = '0;
    set_req(0, 1, 0, 12'h002, 0);
    set_req(1, 1, 0, 12'h012, 0);
    set_req(4, 0, 1, 12'h007, 8'h11);
    set_req(5, 0, 1, 12'h017, 8'h22);
    reset = 1'b0;
    tick();
    checks++;
    if (finish !== 16'h0011) begin
      errors++; $display("FAIL first_grant_core0 got %h required 0011", finish);
    end
    read[0]  = 1'b0;
    write[4] = 1'b0;
    tick();
    checks++;
    if (finish !== 16'h0022) begin
      errors++; $display("FAIL second_grant got %h required 0022", finish);
    end
    checks++;
    if (conflict_cnt !== 16'h1) begin
      errors++; $display("FAIL reset_release_cnt got %h required 1", conflict_cnt);
    end
    drain();
  endtask

  task automatic test_write_read();
    set_req(3, 0, 1, 12'h025, 8'hA5);
    tick();
    checks++;
    if (finish !== 16'h0008) begin
      errors++; $display("FAIL wr_finish3 got %h required 0008", finish);
    end
    write[3] = 1'b0;
    set_req(7, 1, 0, 12'h025, 0);
    tick();
    checks++;
    if (finish !== 16'h0080) begin
      errors++; $display("FAIL rd_finish7 got %h required 0080", finish);
    end
    checks++;
    if (data_out[7*DW +: DW] !== 8'hA5) begin
      errors++; $display("FAIL rd_data7 got %h required a5", data_out[7*DW +: DW]);
    end
    drain();
  endtask

  task automatic test_conflict();
    int c0;
    c0 = m_cnt;
    set_req(0, 1, 0, 12'h005, 0);
    set_req(1, 1, 0, 12'h015, 0);
    set_req(2, 1, 0, 12'h025, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (finish !== NC'(1 << i)) begin
        errors++; $display("FAIL conflict_order step %0d got %h required %h", i, finish, 1 << i);
      end
      read[i] = 1'b0;
    end
    checks++;
    if (data_out[2*DW +: DW] !== 8'hA5) begin
      errors++; $display("FAIL conflict_data2 got %h required a5", data_out[2*DW +: DW]);
    end
    checks++;
    if (conflict_cnt !== 16'(c0 + 2)) begin
      errors++; $display("FAIL conflict_cnt got %0d required %0d", conflict_cnt, c0 + 2);
    end
    tick();
  endtask

  task automatic test_distinct();
    logic [DW-1:0] wv [NC];
    int            wa [NC];
    logic [15:0]   c0;
    c0 = conflict_cnt;
    for (int k = 0; k < NC; k++) begin
      wv[k] = DW'($urandom);
      wa[k] = ($urandom_range(0, 255) << 4) | k;
      set_req(k, 0, 1, wa[k], wv[k]);
    end
    tick();
    checks++;
    if (finish !== 16'hFFFF) begin
      errors++; $display("FAIL distinct_wr_finish got %h required ffff", finish);
    end
    for (int k = 0; k < NC; k++) set_req(k, 1, 0, wa[(k + 1) % NC], 0);
    tick();
    checks++;
    if (finish !== 16'h0000) begin
      errors++; $display("FAIL finish_blocks_regrant got %h required 0000", finish);
    end
    tick();
    checks++;
    if (finish !== 16'hFFFF) begin
      errors++; $display("FAIL distinct_rd_finish got %h required ffff", finish);
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (data_out[k*DW +: DW] !== wv[(k + 1) % NC]) begin
        errors++;
        $display("FAIL distinct_rd_data core %0d got %h required %h", k,
                 data_out[k*DW +: DW], wv[(k + 1) % NC]);
      end
    end
    checks++;
    if (conflict_cnt !== c0) begin
      errors++; $display("FAIL distinct_cnt got %h required %h", conflict_cnt, c0);
    end
    drain();
  endtask

  task automatic test_alternate();
    int  n0, n15;
    logic prev0;
    n0 = 0;
    n15 = 0;
    prev0 = 1'b0;
    set_req(0, 1, 0, 12'h000, 0);
    set_req(15, 1, 0, 12'h010, 0);
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if ((finish[0] ^ finish[15]) !== 1'b1) begin
        errors++;
        $display("FAIL alt_one_each cyc %0d got %b%b required one of two", t, finish[0], finish[15]);
      end
      if (t > 0) begin
        checks++;
        if (finish[0] === prev0) begin
          errors++; $display("FAIL alt_order cyc %0d got %b required %b", t, finish[0], ~prev0);
        end
      end
      prev0 = finish[0];
      if (finish[0])  n0++;
      if (finish[15]) n15++;
    end
    checks++;
    if (n0 < 9 || n0 > 11) begin
      errors++; $display("FAIL alt_count0 got %0d required 10+-1", n0);
    end
    checks++;
    if (n15 < 9 || n15 > 11) begin
      errors++; $display("FAIL alt_count15 got %0d required 10+-1", n15);
    end
    drain();
  endtask

  task automatic test_random();
    bit active [NC];
    int op;
    for (int k = 0; k < NC; k++) active[k] = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < NC; k++) begin
        if (active[k] && m_fin[k]) begin
          active[k] = 1'b0;
          read[k]   = 1'b0;
          write[k]  = 1'b0;
        end
        if (!active[k] && $urandom_range(0, 2) == 0) begin
          op = $urandom_range(0, 3);
          set_req(k, op != 1, op == 1 || op == 2,
                  ($urandom_range(0, 15) << 4) | $urandom_range(0, 3), $urandom);
          active[k] = 1'b1;
        end
      end
      tick();
      checks++;
      if (finish !== m_fin) begin
        errors++; $display("FAIL rand_finish cyc %0d got %h required %h", cyc, finish, m_fin);
      end
      checks++;
      if (conflict_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %0d required %0d", cyc, conflict_cnt, m_cnt);
      end
      for (int k = 0; k < NC; k++) begin
        if (m_known[k]) begin
          checks++;
          if (data_out[k*DW +: DW] !== m_dout[k]) begin
            errors++;
            $display("FAIL rand_data cyc %0d core %0d got %h required %h", cyc, k,
                     data_out[k*DW +: DW], m_dout[k]);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_saturate();
    bit seen;
    seen = 1'b0;
    set_req(0, 1, 0, 12'h000, 0);
    set_req(1, 1, 0, 12'h010, 0);
    set_req(2, 1, 0, 12'h020, 0);
    for (int i = 0; i < 70000 && m_cnt < 65535; i++) begin
      tick();
      if (m_cnt == 65534 && !seen) begin
        seen = 1'b1;
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
          errors++; $display("FAIL sat_near got %h required fffe", conflict_cnt);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h required ffff", conflict_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_req(3, 0, 1, 12'h025, 8'hA5);
    tick();
    write[3] = 1'b0;
    tick();
    set_req(3, 0, 1, 12'h025, 8'h5A);
    reset = 1'b1;
    tick();
    checks++;
    if (finish !== '0) begin
      errors++; $display("FAIL rst_mid_finish got %h required 0", finish);
    end
    reset    = 1'b0;
    write[3] = 1'b0;
    tick();
    checks++;
    if (finish !== '0) begin
      errors++; $display("FAIL rst_mid_late_finish got %h required 0", finish);
    end
    set_req(7, 1, 0, 12'h025, 0);
    tick();
    checks++;
    if (finish !== 16'h0080 || data_out[7*DW +: DW] !== 8'hA5) begin
      errors++;
      $display("FAIL rst_mid_old_value finish %h data %h required 0080 a5", finish,
               data_out[7*DW +: DW]);
    end
    checks++;
    if (conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_mid_cnt got %h required 0", conflict_cnt);
    end
    drain();
  endtask

  task automatic test_small();
    s_write[3]       = 1'b1;
    s_addr[36 +: 12] = 12'h025;
    s_din[48 +: 16]  = 16'hBEEF;
    tick();
    checks++;
    if (s_finish !== 4'b1000) begin
      errors++; $display("FAIL small_wr_finish got %b required 1000", s_finish);
    end
    s_write[3]       = 1'b0;
    s_read[1]        = 1'b1;
    s_addr[12 +: 12] = 12'h025;
    tick();
    checks++;
    if (s_finish !== 4'b0010 || s_dout[16 +: 16] !== 16'hBEEF) begin
      errors++;
      $display("FAIL small_rd finish %b data %h required 0010 beef", s_finish, s_dout[16 +: 16]);
    end
    s_read[1] = 1'b0;
    tick();
    s_write          = 4'b0101;
    s_addr[0 +: 12]  = 12'h024;
    s_addr[24 +: 12] = 12'h033;
    s_din[0 +: 16]   = 16'h1234;
    s_din[32 +: 16]  = 16'h5678;
    tick();
    checks++;
    if (s_finish !== 4'b0101 || s_cnt !== 16'h0) begin
      errors++; $display("FAIL small_parallel finish %b cnt %h required 0101 0", s_finish, s_cnt);
    end
    s_write = '0;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    read    = '0;
    write   = '0;
    addr_in = '0;
    data_in = '0;
    s_read  = '0;
    s_write = '0;
    s_addr  = '0;
    s_din   = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_conflict();
    test_distinct();
    test_alternate();
    test_random();
    test_saturate();
    test_reset_mid();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
